mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, data/address word width.
REQ-002 SHALL have parameter RAM_AW, default 14, RAM word-address width (RAM spans 4<<RAM_AW bytes from byte address 0).
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while a fetch waits.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted when high with i_req_valid.
- i_addr  in  WORD_LEN  fetch byte address.
- i_resp_valid  out  1  one-cycle fetch response pulse.
- i_rdata  out  WORD_LEN  fetched instruction.
- i_err  out  1  fetch error, qualified by i_resp_valid.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted when high with d_req_valid.
- d_addr  in  WORD_LEN  data byte address.
- d_wen  in  1  1 = write, 0 = read.
- d_wstrb  in  4  write byte lanes.
- d_wdata  in  WORD_LEN  write data.
- d_resp_valid  out  1  one-cycle data response pulse (read data or write ack).
- d_rdata  out  WORD_LEN  read data.
- d_err  out  1  data error, qualified by d_resp_valid.
- ram_en  out  1  single-port synchronous RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  WORD_LEN  RAM write data.
- ram_rdata  in  WORD_LEN  RAM read data, valid cycle after ram_en read.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, ERR; i_req_ready/d_req_ready high only in IDLE, never both granted same cycle.
REQ-006 SHALL in IDLE grant data over fetch when both valid, except grant fetch when starve counter equals STARVE_MAX.
REQ-007 SHALL increment starve counter on data grant while i_req_valid high, clear it on any fetch grant or when i_req_valid low, saturate at STARVE_MAX.
REQ-008 SHALL latch address, wen, wstrb, wdata, requester at accept; later input changes SHALL NOT affect the transaction.
REQ-009 SHALL flag error if address[1:0] != 0 or address >= 4<<RAM_AW; errored request SHALL go IDLE->ERR, never assert ram_en, pulse resp_valid with err=1, rdata=0 in cycle after accept, return to IDLE.
REQ-010 SHALL for a legal read accepted in cycle N: ram_en=1, ram_we=0, ram_addr=addr[RAM_AW+1:2] in N+1 (ISSUE); capture ram_rdata at end of N+2 (WAIT); resp_valid and rdata in N+3, state IDLE in N+3.
REQ-011 SHALL for a legal write accepted in N: ram_en=1, ram_we=wstrb, ram_wdata=wdata in N+1; d_resp_valid ack, d_err=0, d_rdata=0 in N+2; IDLE in N+2.
REQ-012 SHALL treat write with d_wstrb=0 as legal no-op: ram_en stays 0, ack in N+2.
REQ-013 SHALL ignore d_wstrb on reads; d_wen is data-port only, fetches always read.
REQ-014 SHALL hold ram_en=0, ram_we=0 outside ISSUE; ram_addr/ram_wdata hold last value.
REQ-015 SHALL hold i_rdata/d_rdata stable until the next response on that port; resp_valid high exactly one cycle per accepted request.
REQ-016 SHALL allow a new request to be accepted in the same cycle a response pulses (back-to-back throughput: one read per 3 cycles).

Reset
REQ-017 SHALL on rst_n low immediately force IDLE, starve counter 0, all outputs 0, regardless of cycle.
REQ-018 SHALL abort any in-flight transaction on reset; no response pulse emitted after release for it.
REQ-019 SHALL accept a request in the first rising edge with rst_n high.

Verification
REQ-020 Read: RAM word 5 = 0x00500093, fetch i_addr=0x14 accepted N -> ram_en/ram_addr=5 at N+1, i_resp_valid, i_rdata=0x00500093, i_err=0 at N+3.
REQ-021 Write: d_addr=0x8, d_wstrb=4'b0011, d_wdata=0xAABBCCDD -> ram_we=4'b0011 at N+1, ack N+2; later read of 0x8 returns 0x????CCDD with untouched upper bytes.
REQ-022 Starvation: d_req_valid and i_req_valid held high continuously -> grants D,D,D,D,I repeating.
REQ-023 Error: d_addr=0x6 read; d_addr=0x10000 (RAM_AW=14) write -> no ram_en, d_resp_valid with d_err=1, d_rdata=0 at N+1.
REQ-024 Reset mid-read: rst_n low in WAIT -> outputs 0 immediately; after release no i_resp_valid until new request.
REQ-025 Simultaneous: both valid in IDLE, counter 0 -> d_req_ready=1, i_req_ready=0; fetch granted next IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share a
// single-port synchronous RAM. Requests are serialised one at a time through a
// small FSM. The data port normally wins when both ports ask at once, and a
// starvation counter forces a fetch grant after STARVE_MAX back-to-back data
// grants. Misaligned or out-of-range addresses are answered with an error
// response and never reach the RAM.
module mem_arbiter #(
  parameter int WORD_LEN   = 32,
  parameter int RAM_AW     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_rdata,
  output logic                i_err,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [3:0]          d_wstrb,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_err,

  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [WORD_LEN-1:0] ram_wdata,
  input  logic [WORD_LEN-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_starve;
  logic                r_isData;
  logic                r_wen;

  logic                r_iRespValid;
  logic [WORD_LEN-1:0] r_iRdata;
  logic                r_iErr;
  logic                r_dRespValid;
  logic [WORD_LEN-1:0] r_dRdata;
  logic                r_dErr;

  logic                r_ramEn;
  logic [3:0]          r_ramWe;
  logic [RAM_AW-1:0]   r_ramAddr;
  logic [WORD_LEN-1:0] r_ramWdata;

  logic                w_idle;
  logic                w_starved;
  logic                w_pickData;
  logic                w_grantData;
  logic                w_grantInstr;
  logic                w_accept;
  logic [WORD_LEN-1:0] w_addr;
  logic                w_wen;
  logic                w_misaligned;
  logic                w_outOfRange;
  logic                w_addrErr;

  // Ready is gated by rst_n so both readies read 0 while reset is held, yet a
  // request can still be taken on the very first edge after release.
  assign w_idle       = rst_n && (r_state == IDLE);
  assign w_starved    = i_req_valid && (r_starve == STARVE_LIM);
  assign w_pickData   = d_req_valid && !w_starved;
  assign d_req_ready  = w_idle && w_pickData;
  assign i_req_ready  = w_idle && !w_pickData;
  assign w_grantData  = d_req_ready && d_req_valid;
  assign w_grantInstr = i_req_ready && i_req_valid;
  assign w_accept     = w_grantData || w_grantInstr;

  // Fetches are always reads, so d_wen only matters for a data grant.
  assign w_addr       = w_grantData ? d_addr : i_addr;
  assign w_wen        = w_grantData && d_wen;
  assign w_misaligned = (w_addr[1:0] != 2'b00);
  assign w_addrErr    = w_misaligned || w_outOfRange;

  // Anything above the top RAM byte address bit means the access is past the RAM.
  generate
    if (RAM_AW + 2 < WORD_LEN) begin : g_rangeCheck
      assign w_outOfRange = |w_addr[WORD_LEN-1:RAM_AW+2];
    end else begin : g_noRangeCheck
      assign w_outOfRange = 1'b0;
    end
  endgenerate

  assign i_resp_valid = r_iRespValid;
  assign i_rdata      = r_iRdata;
  assign i_err        = r_iErr;
  assign d_resp_valid = r_dRespValid;
  assign d_rdata      = r_dRdata;
  assign d_err        = r_dErr;
  assign ram_en       = r_ramEn;
  assign ram_we       = r_ramWe;
  assign ram_addr     = r_ramAddr;
  assign ram_wdata    = r_ramWdata;

  // Starvation counter: counts data grants made while a fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!i_req_valid || w_grantInstr) begin
      r_starve <= '0;
    end else if (w_grantData && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + CW'(1);
    end
  end

  // Transaction FSM with registered RAM strobes and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_isData     <= 1'b0;
      r_wen        <= 1'b0;
      r_iRespValid <= 1'b0;
      r_iRdata     <= '0;
      r_iErr       <= 1'b0;
      r_dRespValid <= 1'b0;
      r_dRdata     <= '0;
      r_dErr       <= 1'b0;
      r_ramEn      <= 1'b0;
      r_ramWe      <= 4'b0000;
      r_ramAddr    <= '0;
      r_ramWdata   <= '0;
    end else begin
      r_iRespValid <= 1'b0;
      r_dRespValid <= 1'b0;
      r_ramEn      <= 1'b0;
      r_ramWe      <= 4'b0000;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_isData <= w_grantData;
            r_wen    <= w_wen;
            if (w_addrErr) begin
              r_state <= ERR;
              if (w_grantData) begin
                r_dRespValid <= 1'b1;
                r_dErr       <= 1'b1;
                r_dRdata     <= '0;
              end else begin
                r_iRespValid <= 1'b1;
                r_iErr       <= 1'b1;
                r_iRdata     <= '0;
              end
            end else begin
              r_state   <= ISSUE;
              r_ramAddr <= w_addr[RAM_AW+1:2];
              if (w_wen) begin
                r_ramEn    <= |d_wstrb;
                r_ramWe    <= d_wstrb;
                r_ramWdata <= d_wdata;
              end else begin
                r_ramEn <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (r_wen) begin
            r_state      <= IDLE;
            r_dRespValid <= 1'b1;
            r_dErr       <= 1'b0;
            r_dRdata     <= '0;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_state <= IDLE;
          if (r_isData) begin
            r_dRespValid <= 1'b1;
            r_dErr       <= 1'b0;
            r_dRdata     <= ram_rdata;
          end else begin
            r_iRespValid <= 1'b1;
            r_iErr       <= 1'b0;
            r_iRdata     <= ram_rdata;
          end
        end
        ERR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural single-port RAM, a reference memory
// image and a scoreboard of expected responses, plus directed checks on RAM
// strobes, arbitration order, error handling and reset behaviour.
module tb_mem_arbiter;

  localparam int WL   = 32;
  localparam int AW   = 14;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_req_valid, i_req_ready, i_resp_valid, i_err;
  logic [WL-1:0] i_addr, i_rdata;
  logic          d_req_valid, d_req_ready, d_wen, d_resp_valid, d_err;
  logic [3:0]    d_wstrb;
  logic [WL-1:0] d_addr, d_wdata, d_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [WL-1:0] ram_wdata, ram_rdata;

  typedef struct {
    bit          isData;
    logic [31:0] data;
    bit          err;
    int          acceptCycle;
    int          lat;
  } expect_t;

  expect_t     sbQueue[$];
  expect_t     monEntry;
  int          checkCount = 0;
  int          errorCount = 0;
  int          cycleCount = 0;
  logic [31:0] mem    [0:(1<<AW)-1];
  logic [31:0] refMem [0:(1<<AW)-1];
  logic [120:0] allOut;

  mem_arbiter #(.WORD_LEN(WL), .RAM_AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wen(d_wen), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign allOut = {i_req_ready, d_req_ready, i_resp_valid, i_rdata, i_err,
                   d_resp_valid, d_rdata, d_err, ram_en, ram_we, ram_addr, ram_wdata};

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure response latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural synchronous RAM with byte-lane writes.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] initWord(int i);
    logic [31:0] v;
    v = {16'hC0DE ^ 16'(i), 16'(i)};
    if (i == 5) v = 32'h00500093;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (i_resp_valid || d_resp_valid)) begin
      checkOutput("single_resp_port", 32'(i_resp_valid & d_resp_valid), 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        monEntry = sbQueue.pop_front();
        checkOutput("resp_port", 32'(d_resp_valid), 32'(monEntry.isData));
        checkOutput("resp_data", monEntry.isData ? d_rdata : i_rdata, monEntry.data);
        checkOutput("resp_err", 32'(monEntry.isData ? d_err : i_err), 32'(monEntry.err));
        checkOutput("resp_latency", 32'(cycleCount - monEntry.acceptCycle), 32'(monEntry.lat));
      end
    end
  end

  task automatic pushExpect(input bit isData, input logic [31:0] addr, input bit wen,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
    expect_t e;
    int idx;
    e.isData = isData;
    e.acceptCycle = cycleCount;
    e.err = 1'b0;
    e.data = 32'd0;
    if (addr[1:0] != 2'b00 || addr >= 32'h0001_0000) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      idx = int'(addr >> 2);
      if (isData && wen) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        e.lat = 2;
      end else begin
        e.data = refMem[idx];
        e.lat = 3;
      end
    end
    sbQueue.push_back(e);
  endtask

  // Drives one request, waits (bounded) for acceptance, then scrambles the inputs.
  task automatic applyStimulus(input bit isData, input logic [31:0] addr, input bit wen,
                               input logic [3:0] wstrb, input logic [31:0] wdata,
                               output int accCycle);
    bit accepted;
    accepted = 1'b0;
    accCycle = -1;
    @(negedge clk);
    if (isData) begin
      d_req_valid = 1'b1; d_addr = addr; d_wen = wen; d_wstrb = wstrb; d_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_addr = addr;
    end
    for (int w = 0; w < 20 && !accepted; w++) begin
      #1;
      if ((isData && d_req_ready) || (!isData && i_req_ready)) begin
        accepted = 1'b1;
        accCycle = cycleCount;
        pushExpect(isData, addr, isData && wen, wstrb, wdata);
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
    d_addr  = $urandom;
    i_addr  = $urandom;
    d_wdata = $urandom;
    d_wstrb = 4'($urandom);
    d_wen   = 1'($urandom);
  endtask

  task automatic waitDrain();
    for (int w = 0; w < 30; w++) begin
      if (sbQueue.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sbQueue.size() != 0) checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
    sbQueue.delete();
  endtask

  task automatic runStarvation();
    int grants;
    bit expD;
    grants = 0;
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h20;
    d_req_valid = 1'b1; d_addr = 32'h40; d_wen = 1'b0; d_wstrb = 4'h0;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      #1;
      if (d_req_ready || i_req_ready) begin
        checkOutput("both_ready", 32'(d_req_ready & i_req_ready), 32'd0);
        expD = (grants % 5) != 4;
        checkOutput($sformatf("starve_grant%0d_is_data", grants), 32'(d_req_ready), 32'(expD));
        if (d_req_ready) pushExpect(1'b1, d_addr, 1'b0, 4'h0, 32'd0);
        else             pushExpect(1'b0, i_addr, 1'b0, 4'h0, 32'd0);
        grants++;
      end
      @(negedge clk);
    end
    if (grants < 10) checkOutput("starve_timeout", 32'(grants), 32'd10);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, prevAcc, relCycle, pulses, r, accD;
    logic [31:0] a;
    bit isD, wn;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] <= initWord(i);
      refMem[i] = initWord(i);
    end
    i_req_valid = 1'b0; i_addr = '0;
    d_req_valid = 1'b0; d_addr = '0; d_wen = 1'b0; d_wstrb = 4'h0; d_wdata = '0;

    // Reset: every output low even with requests pending.
    #2 rst_n = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    checkOutput("reset_outputs_zero", 32'(|allOut), 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    relCycle = cycleCount;

    // Fetch of word 5, accepted on the first edge after release.
    applyStimulus(1'b0, 32'h14, 1'b0, 4'h0, 32'd0, acc);
    checkOutput("accept_first_edge", 32'(acc), 32'(relCycle));
    checkOutput("fetch_ram_en", 32'(ram_en), 32'd1);
    checkOutput("fetch_ram_we", 32'(ram_we), 32'd0);
    checkOutput("fetch_ram_addr", 32'(ram_addr), 32'd5);
    waitDrain();

    // Partial write, then read back through the data port.
    applyStimulus(1'b1, 32'h8, 1'b1, 4'b0011, 32'hAABBCCDD, acc);
    checkOutput("write_ram_en", 32'(ram_en), 32'd1);
    checkOutput("write_ram_we", 32'(ram_we), 32'h3);
    checkOutput("write_ram_addr", 32'(ram_addr), 32'd2);
    checkOutput("write_ram_wdata", ram_wdata, 32'hAABBCCDD);
    waitDrain();
    applyStimulus(1'b1, 32'h8, 1'b0, 4'h0, 32'd0, acc);
    waitDrain();

    // Zero-strobe write is a no-op; strobes on a read are ignored.
    applyStimulus(1'b1, 32'h30, 1'b1, 4'h0, 32'h12345678, acc);
    checkOutput("nop_write_ram_en", 32'(ram_en), 32'd0);
    waitDrain();
    applyStimulus(1'b1, 32'h30, 1'b0, 4'hF, 32'hFFFFFFFF, acc);
    checkOutput("read_strb_ram_en", 32'(ram_en), 32'd1);
    checkOutput("read_strb_ram_we", 32'(ram_we), 32'd0);
    waitDrain();

    // Error cases never touch the RAM.
    applyStimulus(1'b1, 32'h6, 1'b0, 4'h0, 32'd0, acc);
    checkOutput("misaligned_ram_en", 32'(ram_en), 32'd0);
    waitDrain();
    applyStimulus(1'b1, 32'h10000, 1'b1, 4'hF, 32'h55555555, acc);
    checkOutput("range_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    checkOutput("range_ram_en_late", 32'(ram_en), 32'd0);
    waitDrain();
    applyStimulus(1'b0, 32'h10004, 1'b0, 4'h0, 32'd0, acc);
    waitDrain();
    applyStimulus(1'b0, 32'h2, 1'b0, 4'h0, 32'd0, acc);
    waitDrain();

    // Back-to-back reads: one accept every three cycles.
    prevAcc = -1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'(4 * $urandom_range(0, 63)), 1'b0, 4'h0, 32'd0, acc);
      if (k > 0) checkOutput("b2b_spacing", 32'(acc - prevAcc), 32'd3);
      prevAcc = acc;
    end
    waitDrain();

    // Random mix of legal and illegal traffic on both ports.
    for (int k = 0; k < 16; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'h10000 + 32'(4 * $urandom_range(0, 15));
      else if (r == 1) a = 32'(4 * $urandom_range(0, 63)) | 32'($urandom_range(1, 3));
      else             a = 32'(4 * $urandom_range(0, 63));
      isD = ($urandom_range(0, 2) != 0);
      wn  = isD && ($urandom_range(0, 1) == 1);
      applyStimulus(isD, a, wn, 4'($urandom), $urandom, acc);
    end
    waitDrain();

    // Simultaneous requests: data first, fetch in the next idle slot.
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h14;
    d_req_valid = 1'b1; d_addr = 32'h8; d_wen = 1'b0; d_wstrb = 4'h0;
    #1;
    checkOutput("simul_d_ready", 32'(d_req_ready), 32'd1);
    checkOutput("simul_i_ready", 32'(i_req_ready), 32'd0);
    accD = cycleCount;
    pushExpect(1'b1, 32'h8, 1'b0, 4'h0, 32'd0);
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    acc = -1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      #1;
      if (i_req_ready) begin
        acc = cycleCount;
        pushExpect(1'b0, 32'h14, 1'b0, 4'h0, 32'd0);
        break;
      end
    end
    checkOutput("fetch_next_idle", 32'(acc - accD), 32'd3);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    waitDrain();

    // Starvation: D,D,D,D,I repeating with both ports held valid.
    runStarvation();
    waitDrain();

    // Reset during WAIT aborts the fetch with no late response.
    applyStimulus(1'b0, 32'h14, 1'b0, 4'h0, 32'd0, acc);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midread_reset_zero", 32'(|allOut), 32'd0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_resp_valid || d_resp_valid) pulses++;
    end
    checkOutput("no_resp_after_reset", 32'(pulses), 32'd0);
    checkOutput("i_rdata_held_zero", i_rdata, 32'd0);
    applyStimulus(1'b0, 32'h14, 1'b0, 4'h0, 32'd0, acc);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
